// File: rtl/surf_trig_pkg.sv
// Shared types and constants for the SURF trigger generator.
package surf_trig_pkg;

  localparam int unsigned ADDR_W      = 12;
  localparam logic [1:0]  TRIG_MARKER = 2'b10;

  typedef struct packed {
    logic [7:0]        rsvd_hi;
    logic [7:0]        meta;
    logic [1:0]        marker;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        rsvd_lo;
  } trig_word_t;

  typedef enum logic {
    RUN_IDLE,
    RUN_ACTIVE
  } run_state_t;

  function automatic int unsigned MASK_WORDS(input int unsigned n);
    return (n + 32'd31) / 32'd32;
  endfunction

endpackage

// File: rtl/surf_trig_gen_multi_beam_lowest_idx.sv
// Registered priority encoder: index of the lowest set beam, one cycle latency.
module beam_lowest_idx #(
  parameter int unsigned NBEAMS = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NBEAMS-1:0] vec,
  output logic [7:0]        idx
);

  logic [7:0] lowest;

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    lowest = '0;
    for (int unsigned i = NBEAMS; i > 0; i--) begin
      if (vec[i-1]) lowest = 8'(i - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) idx <= '0;
    else     idx <= lowest;
  end

endmodule

// File: rtl/surf_trig_gen_multi.sv
// Multi-beam trigger generator: masked beams, holdoff, address tagging, FWFT FIFO to AXI4-Stream.
// Optional trigger/drop counters with SURF_TRIG_GEN_STATS_EN.
module surf_trig_gen_multi
  import surf_trig_pkg::*;
#(
  parameter int unsigned NBEAMS      = 48,
  parameter int unsigned FIFO_DEPTH  = 512,
  parameter int unsigned HOLDOFF_MIN = 8
) (
  input  logic              ifclk,
  input  logic              gen_rst_i,
  input  logic [NBEAMS-1:0] trig_i,
  input  logic              mask_wr_i,
  input  logic [2:0]        mask_addr_i,
  input  logic [31:0]       mask_dat_i,
  input  logic              mask_update_i,
  input  logic [7:0]        holdoff_i,
  input  logic [11:0]       offset_i,
  input  logic              runrst_i,
  input  logic              runstop_i,
  output logic [31:0]       trig_tdata,
  output logic              trig_tvalid,
  input  logic              trig_tready
`ifdef SURF_TRIG_GEN_STATS_EN
  ,
  output logic [31:0]       trig_count_o,
  output logic [15:0]       drop_count_o
`endif
);

  localparam int unsigned NWORDS = MASK_WORDS(NBEAMS);
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);

  logic [NBEAMS-1:0] stage_mask, active_mask;
  logic [NBEAMS-1:0] trig_q, masked_q;
  logic              hit_q;
  logic [7:0]        meta_q;

  run_state_t        run_state;
  logic [11:0]       cur_addr, offset_q;

  logic [7:0]        holdoff_cnt, holdoff_len;
  logic              accept;
  trig_word_t        acc_word;
  logic              wr_v_q;
  logic [31:0]       wr_word_q;

  logic [31:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              fifo_full, push, pop;

  // Mask staging/active pair; an update copies staging as it stood before any same-cycle write.
  always_ff @(posedge ifclk) begin
    if (gen_rst_i) begin
      stage_mask  <= '1;
      active_mask <= '1;
    end else begin
      if (mask_update_i) active_mask <= stage_mask;
      if (mask_wr_i && (32'(mask_addr_i) < NWORDS)) begin
        for (int unsigned i = 0; i < NBEAMS; i++) begin
          if ((i / 32) == 32'(mask_addr_i)) stage_mask[i] <= mask_dat_i[i % 32];
        end
      end
    end
  end

  always_ff @(posedge ifclk) begin
    if (gen_rst_i) begin
      run_state <= RUN_IDLE;
      cur_addr  <= 12'd1;
      offset_q  <= '0;
    end else if (runrst_i) begin
      run_state <= RUN_ACTIVE;
      cur_addr  <= 12'd1;
      offset_q  <= offset_i;
    end else if (runstop_i) begin
      run_state <= RUN_IDLE;
      cur_addr  <= 12'd1;
    end else if (run_state == RUN_ACTIVE) begin
      cur_addr  <= cur_addr + 12'd1;
    end else begin
      cur_addr  <= 12'd1;
    end
  end

  always_ff @(posedge ifclk) begin
    if (gen_rst_i) begin
      trig_q   <= '0;
      masked_q <= '0;
      hit_q    <= 1'b0;
    end else begin
      trig_q   <= trig_i;
      masked_q <= trig_q & ~active_mask;
      hit_q    <= |masked_q;
    end
  end

  beam_lowest_idx #(.NBEAMS(NBEAMS)) u_lowest (
    .clk (ifclk),
    .rst (gen_rst_i),
    .vec (masked_q),
    .idx (meta_q)
  );

  assign holdoff_len = (holdoff_i < 8'(HOLDOFF_MIN)) ? 8'(HOLDOFF_MIN) : holdoff_i;
  assign accept      = hit_q && (run_state == RUN_ACTIVE) && (holdoff_cnt == '0);

  always_comb begin
    acc_word        = '0;
    acc_word.meta   = meta_q;
    acc_word.marker = TRIG_MARKER;
    acc_word.addr   = cur_addr + offset_q;
  end

  // Holdoff is loaded on every acceptance, whether or not the FIFO has room.
  always_ff @(posedge ifclk) begin
    if (gen_rst_i) begin
      holdoff_cnt <= '0;
      wr_v_q      <= 1'b0;
      wr_word_q   <= '0;
    end else begin
      if (accept)                 holdoff_cnt <= holdoff_len - 8'd1;
      else if (holdoff_cnt != '0) holdoff_cnt <= holdoff_cnt - 8'd1;
      wr_v_q    <= accept;
      wr_word_q <= acc_word;
    end
  end

  assign fifo_full   = (count == (AW+1)'(FIFO_DEPTH));
  assign trig_tvalid = (count != '0);
  assign pop         = trig_tvalid && trig_tready;
  assign push        = wr_v_q && (!fifo_full || pop);
  assign trig_tdata  = trig_tvalid ? mem[rd_ptr] : '0;

  always_ff @(posedge ifclk) begin
    if (push) mem[wr_ptr] <= wr_word_q;
  end

  always_ff @(posedge ifclk) begin
    if (gen_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef SURF_TRIG_GEN_STATS_EN
  logic drop;
  assign drop = wr_v_q && fifo_full && !pop;

  always_ff @(posedge ifclk) begin
    if (gen_rst_i || runrst_i) begin
      trig_count_o <= '0;
      drop_count_o <= '0;
    end else begin
      if (push) trig_count_o <= trig_count_o + 32'd1;
      if (drop && (drop_count_o != '1)) drop_count_o <= drop_count_o + 16'd1;
    end
  end
`endif

endmodule

// File: doc/surf_trig_gen_multi.md
# surf_trig_gen_multi

Parametrised successor trigger generator for the SURF. It operates entirely in the `ifclk` domain, downstream of the aclk→ifclk stretch. Beams are masked per beam through a double-buffered mask, and accepted triggers obey a programmable holdoff. Each accepted trigger is tagged with a 12-bit capture address plus metadata, and the tagged words are queued as 32-bit AXI4-Stream to the TURF link. It generalises the fixed 48-beam generator to up to 256 beams, adds run-gating, configurable holdoff and FIFO depth, and reports full-FIFO drops.

## Interface
Parameters:
- `NBEAMS`, 48. Number of beams, 1..256.
- `FIFO_DEPTH`, 512. Output FIFO depth in words; must be a power of 2, at least 16.
- `HOLDOFF_MIN`, 8. Minimum spacing between accepted triggers, in clocks.

Ports:
- `ifclk` in 1: single clock.
- `gen_rst_i` in 1: synchronous, active-high reset.
- `trig_i` in NBEAMS: per-beam trigger, already in the ifclk domain.
- `mask_wr_i` in 1: write `mask_dat_i` into staging word `mask_addr_i`.
- `mask_addr_i` in 3: staging word index; word k covers beams 32k..32k+31.
- `mask_dat_i` in 32: mask data; 1 = beam disabled.
- `mask_update_i` in 1: copy staging mask to active mask.
- `holdoff_i` in 8: holdoff length in clocks; values below HOLDOFF_MIN act as HOLDOFF_MIN.
- `offset_i` in 12: address offset, latched on `runrst_i`.
- `runrst_i` in 1: start run.
- `runstop_i` in 1: stop run.
- `trig_tdata` out 32, `trig_tvalid` out 1, `trig_tready` in 1: AXI4-Stream output.
- `trig_count_o` out 32, `drop_count_o` out 16: present only with the stats macro.

## Operation
Mask path:
- Staging and active masks are NBEAMS bits each. Both reset to all ones, so every beam is masked after reset.
- Writes to staging bits at or above NBEAMS are ignored. Out-of-range `mask_addr_i` is ignored.

Run control:
- `runrst_i` sets `running`, latches `offset_i`, and loads `current_address` with 1.
- `runstop_i` clears `running`. If `runrst_i` and `runstop_i` arrive together, `runrst_i` wins.
- While `running` is 0, `current_address` is held at 1.
- While `running` is 1, `current_address` increments every clock and wraps from 4095 to 0.

Pipeline and trigger acceptance:
- S1: register `trig_i`.
- S2: `masked = trig_q & ~active_mask`. `any = |masked`.
- S3: priority-encode the lowest set bit of `masked` into `meta[7:0]`.
- A trigger is accepted in S3 only if `any` is set, `running` is 1, and `holdoff_cnt` is 0. All three conditions are evaluated in the same cycle.
- On acceptance:
  - load `holdoff_cnt = max(holdoff_i, HOLDOFF_MIN) - 1`; the counter decrements to 0;
  - capture `addr = current_address + offset` modulo 4096;
  - form the output word `{8'h00, meta, 2'b10, addr, 2'b00}`.

FIFO and output:
- The FIFO is first-word-fall-through. A word is popped when `trig_tvalid && trig_tready`.
- When the FIFO is full, an accepted trigger is dropped: no write occurs, but holdoff is still loaded.
- A pop and a push in the same cycle on a full FIFO is allowed; the push succeeds.

Reset (`gen_rst_i`), including mid-operation:
- Clears pipeline, holdoff, `running`, address, offset, FIFO and counters. Sets both masks to all ones.
- Reset values: `trig_tvalid` = 0, `trig_tdata` = 0, `trig_count_o` = 0, `drop_count_o` = 0.
- Words still in the FIFO at reset are discarded.

## Timing
Trigger latency:
- Input edge N (`trig_i` sampled): S1 at N+1, S2 at N+2, accept at N+3, FIFO write at N+4.
- `trig_tvalid` is high at N+5 if the FIFO was empty.

Mask timing:
- `mask_update_i` at cycle M: the new mask applies to S2 at M+1 onward.
- `mask_wr_i` and `mask_update_i` in the same cycle: the update copies the old staging contents.

Holdoff spacing:
- Accepted triggers are at least max(`holdoff_i`, HOLDOFF_MIN) cycles apart.
- A trigger arriving during holdoff is lost; it is not deferred.

Address:
- `addr` is taken from the same cycle as acceptance.

AXI4-Stream rules:
- `trig_tdata` is stable while `trig_tvalid && !trig_tready`.
- `trig_tvalid` never drops without a handshake, except on reset.

## Configuration
Macro `SURF_TRIG_GEN_STATS_EN`:
- Defined:
  - `trig_count_o` increments on each successful FIFO write and wraps.
  - `drop_count_o` increments on each full-FIFO drop and saturates at 16'hFFFF.
  - Both clear on `gen_rst_i` and on `runrst_i`.
- Undefined: both ports and both counters are absent. Drop behaviour is unchanged.

## Structure
- Package `surf_trig_pkg` holds:
  - `trig_word_t`, a packed struct for the output word (meta, marker, addr);
  - `TRIG_MARKER = 2'b10`;
  - `ADDR_W = 12`;
  - `MASK_WORDS(n) = (n+31)/32`.
- Sub-module `beam_lowest_idx`: parametrised registered priority encoder, NBEAMS to 8 bits, latency 1 cycle.
- The FIFO is an inferred synchronous FWFT buffer inside the block.

## Test plan
1. Reset, `mask_dat_i = 0` written to all words, update, `runrst_i` with `offset_i = 0x010`, pulse beam 5 at run-cycle 20.
   - Expect one word: meta = 5, addr = 20 + 0x010 + 1 per latency accounting.
   - Expect `trig_tvalid` at N+5.
2. `holdoff_i = 3`, beam pulses 4 clocks apart: only every second pulse is accepted.
   - Repeat with `holdoff_i = 20`: accepted pulses are at least 20 cycles apart.
3. Beams 7 and 40 high together, beam 7 masked via staging without update, then after update.
   - Before update: meta = 7.
   - After update: meta = 40.
4. `trig_tready = 0`, triggers spaced 8 clocks apart until FIFO_DEPTH + 3 are issued.
   - Expect exactly 3 drops and `drop_count_o = 3`.
   - Expect FIFO contents intact in order after `trig_tready` rises.
5. Triggers with `running` = 0 produce no words.
   - `runrst_i` and `runstop_i` asserted together leave `running` = 1.
   - Address wraps 4095 to 0 with `offset_i = 0xFFF`.
6. `gen_rst_i` asserted with 4 words queued and holdoff active.
   - Next cycle: `trig_tvalid` = 0, counters 0, all beams masked.
